instr_sequencer: RTL

Fetch/decode/execute sequencer for the 8-bit CPU.
- Drives the PC, MAR, memory read, IR and operand temp registers through a fixed microstep schedule, then hands execute microsteps to the datapath decoder.
- Sits inside `cpu` between the opcode decoder (supplies length, step count and halt) and the register/ALU datapath.
- Produces the per-instruction phase timing: 4-cycle opcode fetch, 4 cycles per extra byte, N execute steps, 1 latch cycle.

---
 rtl/instr_sequencer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute microstep sequencer for the 8-bit CPU.
// Define SEQ_SINGLE_STEP_EN to gate each instruction on step_req_i.
module instr_sequencer #(
  parameter int MAX_BYTES = 3,
  parameter int STEP_W    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_ready_i,
  input  logic [1:0]        instr_len_i,
  input  logic [STEP_W-1:0] exec_steps_i,
  input  logic              is_halt_i,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic              step_req_i,
`endif
  output logic              mar_load_o,
  output logic              mem_rd_o,
  output logic              ir_load_o,
  output logic              temp1_load_o,
  output logic              temp2_load_o,
  output logic              pc_inc_o,
  output logic              exec_o,
  output logic [STEP_W-1:0] step_o,
  output logic              latch_o,
  output logic              halted_o,
  output logic [3:0]        state_o
);

  typedef enum logic [3:0] {
    RST      = 4'd0,
    F_ADDR   = 4'd1,
    F_READ   = 4'd2,
    F_LOAD   = 4'd3,
    CHK_MORE = 4'd4,
    OP_ADDR  = 4'd5,
    OP_READ  = 4'd6,
    OP_LOAD  = 4'd7,
    EXEC     = 4'd8,
    LATCH    = 4'd9,
    HALT     = 4'd10
  } state_e;

  localparam logic [STEP_W-1:0] STEP_ONE = 1;

  state_e            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic [1:0]        len_eff;
`ifdef SEQ_SINGLE_STEP_EN
  logic              hold_q, hold_d;
`endif

  // Zero-length opcodes still occupy one byte; oversize ones clamp.
  always_comb begin
    if (instr_len_i == 2'd0)
      len_eff = 2'd1;
    else if (int'(instr_len_i) > MAX_BYTES)
      len_eff = 2'(MAX_BYTES);
    else
      len_eff = instr_len_i;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RST;
      byte_cnt_q <= '0;
      step_q     <= '0;
      steps_q    <= '0;
`ifdef SEQ_SINGLE_STEP_EN
      hold_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      step_q     <= step_d;
      steps_q    <= steps_d;
`ifdef SEQ_SINGLE_STEP_EN
      hold_q     <= hold_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    step_d     = step_q;
    steps_d    = steps_q;
`ifdef SEQ_SINGLE_STEP_EN
    hold_d     = hold_q;
`endif
    unique case (state_q)
      RST: begin
        state_d = F_ADDR;
`ifdef SEQ_SINGLE_STEP_EN
        hold_d  = 1'b1;
`endif
      end
      F_ADDR: begin
`ifdef SEQ_SINGLE_STEP_EN
        if (hold_q) begin
          if (step_req_i) hold_d = 1'b0;
        end else begin
          state_d = F_READ;
        end
`else
        state_d = F_READ;
`endif
      end
      F_READ: if (mem_ready_i) state_d = F_LOAD;
      F_LOAD: begin
        byte_cnt_d = 2'd1;
        state_d    = CHK_MORE;
      end
      CHK_MORE: begin
        if (is_halt_i) begin
          state_d = HALT;
        end else if (byte_cnt_q < len_eff) begin
          state_d = OP_ADDR;
        end else if (exec_steps_i != '0) begin
          state_d = EXEC;
          steps_d = exec_steps_i;
          step_d  = '0;
        end else begin
          state_d = LATCH;
        end
      end
      OP_ADDR: state_d = OP_READ;
      OP_READ: if (mem_ready_i) state_d = OP_LOAD;
      OP_LOAD: begin
        byte_cnt_d = byte_cnt_q + 2'd1;
        state_d    = CHK_MORE;
      end
      EXEC: begin
        if (step_q == steps_q - STEP_ONE)
          state_d = LATCH;
        else
          step_d = step_q + STEP_ONE;
      end
      LATCH: begin
        state_d = F_ADDR;
`ifdef SEQ_SINGLE_STEP_EN
        hold_d  = 1'b1;
`endif
      end
      HALT:    state_d = HALT;
      default: state_d = RST;
    endcase
  end

  always_comb begin
    mar_load_o   = 1'b0;
    mem_rd_o     = 1'b0;
    ir_load_o    = 1'b0;
    temp1_load_o = 1'b0;
    temp2_load_o = 1'b0;
    pc_inc_o     = 1'b0;
    exec_o       = 1'b0;
    step_o       = '0;
    latch_o      = 1'b0;
    halted_o     = 1'b0;
    state_o      = state_q;
    unique case (state_q)
`ifdef SEQ_SINGLE_STEP_EN
      F_ADDR:  mar_load_o = !hold_q;
`else
      F_ADDR:  mar_load_o = 1'b1;
`endif
      OP_ADDR: mar_load_o = 1'b1;
      F_READ,
      OP_READ: mem_rd_o = 1'b1;
      F_LOAD: begin
        mem_rd_o  = 1'b1;
        ir_load_o = 1'b1;
        pc_inc_o  = 1'b1;
      end
      OP_LOAD: begin
        mem_rd_o     = 1'b1;
        pc_inc_o     = 1'b1;
        temp1_load_o = (byte_cnt_q == 2'd1);
        temp2_load_o = (byte_cnt_q == 2'd2);
      end
      EXEC: begin
        exec_o = 1'b1;
        step_o = step_q;
      end
      LATCH:   latch_o  = 1'b1;
      HALT:    halted_o = 1'b1;
      default: ;
    endcase
  end

endmodule
